// File: rtl/wb8_uart_bus_master.sv
// wb8_uart_bus_master: byte-command Wishbone initiator driven by a UART byte stream
module wb8_uart_bus_master #(
  parameter int BUS_TIMEOUT = 1024,
  parameter int RX_TIMEOUT = 16777215
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [7:0]  I_rx_data,
  input  logic        I_rx_valid,
  output logic [7:0]  O_tx_data,
  output logic        O_tx_valid,
  input  logic        I_tx_ready,
  output logic [31:0] ADR_O,
  output logic [7:0]  DAT_O,
  input  logic [7:0]  DAT_I,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I,
  output logic        O_busy,
  output logic        O_drop
);
  localparam int RW = $clog2(RX_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [7:0] NAK_B = 8'h15;
  localparam logic [7:0] ACK_B = 8'h06;
  typedef enum logic [2:0] {IDLE, ADDR, LEN, WDATA, WBUS, RBUS, RSEND, ACKSEND} state_t;
  state_t state;
  logic [1:0] acnt;
  logic [8:0] cnt;
  logic [RW-1:0] rx_tmr;
  logic [BW-1:0] bus_tmr;
  logic tx_free, rx_wait, rx_expire;
  assign tx_free = !O_tx_valid || I_tx_ready;
  assign rx_wait = state == ADDR || state == LEN || state == WDATA;
  assign rx_expire = rx_wait && !I_rx_valid && rx_tmr == RW'(RX_TIMEOUT);
  assign STB_O = CYC_O;
  // frame parser, bus cycle sequencer and response queue
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= IDLE;
      ADR_O <= '0;
      DAT_O <= '0;
      CYC_O <= 1'b0;
      WE_O <= 1'b0;
      O_tx_data <= '0;
      O_tx_valid <= 1'b0;
      O_busy <= 1'b0;
      O_drop <= 1'b0;
      acnt <= '0;
      cnt <= '0;
      rx_tmr <= '0;
      bus_tmr <= '0;
    end else begin
      O_drop <= 1'b0;
      if (O_tx_valid && I_tx_ready) O_tx_valid <= 1'b0;
      rx_tmr <= (rx_wait && !I_rx_valid) ? rx_tmr + 1'b1 : '0;
      case (state)
        IDLE: if (I_rx_valid) begin
          if (I_rx_data == 8'h57 || I_rx_data == 8'h52) begin
            WE_O <= I_rx_data == 8'h57;
            acnt <= '0;
            state <= ADDR;
            O_busy <= 1'b1;
          end else if (tx_free) begin
            O_tx_data <= NAK_B;
            O_tx_valid <= 1'b1;
          end else O_drop <= 1'b1;
        end
        ADDR: if (I_rx_valid) begin
          ADR_O <= {ADR_O[23:0], I_rx_data};
          acnt <= acnt + 1'b1;
          if (acnt == 2'd3) state <= LEN;
        end
        LEN: if (I_rx_valid) begin
          cnt <= {I_rx_data == 8'h00, I_rx_data};
          state <= WE_O ? WDATA : RBUS;
        end
        WDATA: if (I_rx_valid) begin
          DAT_O <= I_rx_data;
          state <= WBUS;
        end
        WBUS, RBUS: begin
          O_drop <= I_rx_valid;
          if (!CYC_O) begin
            if (state == WBUS || !O_tx_valid) begin
              CYC_O <= 1'b1;
              bus_tmr <= '0;
            end
          end else if (ACK_I) begin
            CYC_O <= 1'b0;
            ADR_O <= ADR_O + 32'd1;
            cnt <= cnt - 1'b1;
            if (state == RBUS) begin
              O_tx_data <= DAT_I;
              O_tx_valid <= 1'b1;
              state <= RSEND;
            end else state <= cnt == 9'd1 ? ACKSEND : WDATA;
          end else if (bus_tmr == BW'(BUS_TIMEOUT - 1)) begin
            CYC_O <= 1'b0;
            state <= IDLE;
            O_busy <= 1'b0;
            if (tx_free) begin
              O_tx_data <= NAK_B;
              O_tx_valid <= 1'b1;
            end
          end else bus_tmr <= bus_tmr + 1'b1;
        end
        RSEND: begin
          O_drop <= I_rx_valid;
          if (I_tx_ready) begin
            state <= cnt == 9'd0 ? IDLE : RBUS;
            O_busy <= cnt != 9'd0;
          end
        end
        ACKSEND: begin
          O_drop <= I_rx_valid;
          if (tx_free) begin
            O_tx_data <= ACK_B;
            O_tx_valid <= 1'b1;
            state <= IDLE;
            O_busy <= 1'b0;
          end
        end
      endcase
      if (rx_expire) begin
        state <= IDLE;
        O_busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb8_uart_bus_master.sv
// tb_wb8_uart_bus_master: directed vector bench with Wishbone responder and tx monitor
module tb_wb8_uart_bus_master;
  localparam int BT = 8;
  localparam int RXT = 30;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic rx_valid = 0, tx_ready = 0;
  logic [7:0] tx_data, dat_o;
  logic [7:0] dat_i = 0;
  logic tx_valid, cyc, stb, we, busy, drop;
  logic ack = 0, ack_en = 1, prev_stb = 0;
  logic [31:0] adr;
  logic [7:0] mem [logic [31:0]];
  logic [31:0] bus_adr_q[$];
  logic bus_we_q[$];
  logic [7:0] bus_dat_q[$];
  logic [7:0] tx_q[$];
  int stb_cycles = 0, bus_starts = 0, drops = 0;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [7:0] cmd; logic busy; logic txv; logic [7:0] txd; } vec_t;
  vec_t vecs [6];

  wb8_uart_bus_master #(.BUS_TIMEOUT(BT), .RX_TIMEOUT(RXT)) dut (
    .CLK_I(clk), .RST_I(rst), .I_rx_data(rx_data), .I_rx_valid(rx_valid),
    .O_tx_data(tx_data), .O_tx_valid(tx_valid), .I_tx_ready(tx_ready),
    .ADR_O(adr), .DAT_O(dat_o), .DAT_I(dat_i), .CYC_O(cyc), .STB_O(stb),
    .WE_O(we), .ACK_I(ack), .O_busy(busy), .O_drop(drop)
  );

  initial forever #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] rd_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    case (a)
      32'hFFFFF800: return 8'h11;
      32'hFFFFF801: return 8'h22;
      32'hFFFFF802: return 8'h33;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(negedge clk) begin
    if (ack) ack = 1'b0;
    else if (cyc && stb && ack_en) begin
      ack = 1'b1;
      bus_adr_q.push_back(adr);
      bus_we_q.push_back(we);
      bus_dat_q.push_back(we ? dat_o : rd_val(adr));
      if (we) mem[adr] = dat_o;
      else dat_i = rd_val(adr);
    end
    if (stb) stb_cycles++;
    if (stb && !prev_stb) bus_starts++;
    prev_stb = stb;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (drop) drops++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send6(input logic [7:0] c, input logic [31:0] a, input logic [7:0] len);
    send_byte(c, 4);
    send_byte(a[31:24], 4);
    send_byte(a[23:16], 4);
    send_byte(a[15:8], 4);
    send_byte(a[7:0], 4);
    send_byte(len, 4);
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int i = 0; i < max && (busy || tx_valid); i++) tick();
    check(name, {30'd0, busy, tx_valid}, 32'd0);
  endtask

  initial begin
    int b, t, s, d, bad_adr, bad_dat;
    vecs[0] = '{8'h41, 1'b0, 1'b1, 8'h15};
    vecs[1] = '{8'h52, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h15};
    vecs[3] = '{8'h57, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 8'h15};
    vecs[5] = '{8'h72, 1'b0, 1'b1, 8'h15};
    repeat (3) tick();
    check("rst_adr", adr, 0);
    check("rst_dat", {24'd0, dat_o}, 0);
    check("rst_ctl", {27'd0, cyc, stb, we, busy, drop}, 0);
    check("rst_tx", {23'd0, tx_valid, tx_data}, 0);
    rst = 0;
    tick();

    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].cmd, 2);
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      check($sformatf("vec%0d_txv", i), {31'd0, tx_valid}, {31'd0, vecs[i].txv});
      if (vecs[i].txv) check($sformatf("vec%0d_txd", i), {24'd0, tx_data}, {24'd0, vecs[i].txd});
      if (vecs[i].busy) begin
        repeat (RXT + 5) tick();
        check($sformatf("vec%0d_rxto", i), {30'd0, busy, tx_valid}, 0);
      end
      tx_ready = 1;
      tick();
      tx_ready = 0;
    end
    check("vec_no_bus", bus_adr_q.size(), 0);

    d = drops;
    send_byte(8'h41, 1);
    send_byte(8'h42, 0);
    check("nakblk_drop", {31'd0, drop}, 1);
    check("nakblk_txd", {24'd0, tx_data}, 8'h15);
    tx_ready = 1;
    tick();
    check("nakblk_drops", drops - d, 1);
    check("nakblk_txv", {31'd0, tx_valid}, 0);

    b = bus_adr_q.size();
    t = tx_q.size();
    send6(8'h57, 32'h00000100, 8'h02);
    send_byte(8'hAA, 4);
    send_byte(8'hBB, 4);
    wait_idle("wr_idle", 50);
    check("wr_count", bus_adr_q.size() - b, 2);
    if (bus_adr_q.size() >= b + 2) begin
      check("wr0", {bus_adr_q[b][23:0], bus_dat_q[b]}, {24'h000100, 8'hAA});
      check("wr1", {bus_adr_q[b+1][23:0], bus_dat_q[b+1]}, {24'h000101, 8'hBB});
      check("wr_we", {30'd0, bus_we_q[b], bus_we_q[b+1]}, 3);
    end
    check("wr_txn", tx_q.size() - t, 1);
    if (tx_q.size() > t) check("wr_ack", {24'd0, tx_q[t]}, 8'h06);

    tx_ready = 0;
    s = bus_starts;
    t = tx_q.size();
    send6(8'h52, 32'hFFFFF800, 8'h03);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 50 && !tx_valid; i++) tick();
      repeat (20) tick();
      check($sformatf("rd_starts%0d", k), bus_starts - s, k + 1);
      check($sformatf("rd_held%0d", k), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h11 * 8'(k + 1)});
      tx_ready = 1;
      tick();
      tx_ready = 0;
    end
    wait_idle("rd_idle", 50);
    check("rd_total", bus_starts - s, 3);
    check("rd_txn", tx_q.size() - t, 3);
    if (tx_q.size() >= t + 3) check("rd_bytes", {8'd0, tx_q[t], tx_q[t+1], tx_q[t+2]}, 32'h00112233);

    tx_ready = 1;
    b = bus_adr_q.size();
    t = tx_q.size();
    send6(8'h52, 32'hFFFFFFFF, 8'h00);
    wait_idle("wrap_idle", 4000);
    check("wrap_count", bus_adr_q.size() - b, 256);
    check("wrap_txn", tx_q.size() - t, 256);
    bad_adr = 0;
    bad_dat = 0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] ea;
      ea = 32'hFFFFFFFF + 32'(i);
      if (b + i < bus_adr_q.size() && (bus_adr_q[b+i] !== ea || bus_we_q[b+i] !== 1'b0)) bad_adr++;
      if (t + i < tx_q.size() && tx_q[t+i] !== (ea[7:0] ^ 8'h5A)) bad_dat++;
    end
    check("wrap_bad_adr", bad_adr, 0);
    check("wrap_bad_dat", bad_dat, 0);
    check("wrap_adr_end", adr, 32'h000000FF);

    ack_en = 0;
    b = bus_adr_q.size();
    s = stb_cycles;
    t = tx_q.size();
    send6(8'h52, 32'h00002000, 8'h01);
    wait_idle("to_idle", 60);
    check("to_stb_cycles", stb_cycles - s, BT);
    check("to_cyc", {30'd0, cyc, stb}, 0);
    check("to_no_ack", bus_adr_q.size() - b, 0);
    check("to_txn", tx_q.size() - t, 1);
    if (tx_q.size() > t) check("to_nak", {24'd0, tx_q[t]}, 8'h15);
    ack_en = 1;

    t = tx_q.size();
    send_byte(8'h57, 0);
    send_byte(8'h00, RXT + 8);
    check("rxto_busy", {31'd0, busy}, 0);
    check("rxto_no_tx", tx_q.size() - t, 0);
    send6(8'h52, 32'h00000100, 8'h01);
    wait_idle("rxto_rd_idle", 50);
    check("rxto_rd_txn", tx_q.size() - t, 1);
    if (tx_q.size() > t) check("rxto_rd_data", {24'd0, tx_q[t]}, 8'hAA);

    b = bus_adr_q.size();
    t = tx_q.size();
    d = drops;
    send6(8'h57, 32'h00000200, 8'h01);
    send_byte(8'h5C, 0);
    send_byte(8'h99, 0);
    check("drop_pulse", {31'd0, drop}, 1);
    wait_idle("drop_idle", 50);
    check("drop_count", drops - d, 1);
    check("drop_writes", bus_adr_q.size() - b, 1);
    if (bus_adr_q.size() > b) check("drop_wr", {bus_adr_q[b][23:0], bus_dat_q[b]}, {24'h000200, 8'h5C});
    check("drop_txn", tx_q.size() - t, 1);
    if (tx_q.size() > t) check("drop_ack", {24'd0, tx_q[t]}, 8'h06);

    ack_en = 0;
    send6(8'h52, 32'h00000300, 8'h01);
    check("mid_stb", {31'd0, stb}, 1);
    rst = 1;
    tick();
    check("mid_adr", adr, 0);
    check("mid_dat", {24'd0, dat_o}, 0);
    check("mid_ctl", {27'd0, cyc, stb, we, busy, drop}, 0);
    check("mid_tx", {23'd0, tx_valid, tx_data}, 0);
    rst = 0;
    ack_en = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
